// File: rtl/hc_pkg.sv
// ============================================================================
// hc_pkg : shared width, pipeline depth and output-FSM states for hc646n.
// Macro  : HC646N_SYNC_EN selects a 2-deep input pipeline (default 1-deep).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hc_pkg;

  localparam int HC_W = 8;

`ifdef HC646N_SYNC_EN
  localparam int HC_D = 2;
`else
  localparam int HC_D = 1;
`endif

  typedef enum logic [1:0] {
    HIZ   = 2'd0,
    TURN  = 2'd1,
    DRIVE = 2'd2
  } hc_state_e;

endpackage

`default_nettype wire

// File: rtl/hc646n_if.sv
// ============================================================================
// hc646n_if : pin bundle of the hc646n transceiver; b is the 3-state B port.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface hc646n_if import hc_pkg::*; ();

  logic            p1;      // CPAB
  logic            p2;      // SAB
  logic            p3;      // DIR
  logic            p21;     // OE#
  logic [HC_W-1:0] a;       // a[0] = A1 = p4
  logic [HC_W-1:0] b_dat;   // b[0] = B1 = p20
  logic            b_oe;
  wire  [HC_W-1:0] b;

  // Pad-level tri-state; the core only produces data and enable.
  assign b = b_oe ? b_dat : {HC_W{1'bz}};

  modport master (output p1, p2, p3, p21, a, input b_dat, b_oe, b);
  modport slave  (input p1, p2, p3, p21, a, output b_dat, b_oe);

endinterface

`default_nettype wire

// File: rtl/hc_edge_sync.sv
// ============================================================================
// hc_edge_sync : p1 synchroniser, matching A pipeline and rising-edge detect.
// Macro        : HC646N_SYNC_EN sets pipeline depth 2 (else 1).
// Rev          : 1.0
// ============================================================================
`default_nettype none

module hc_edge_sync import hc_pkg::*; (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            p1,
  input  wire logic [HC_W-1:0] a,
  output      logic            cap,
  output      logic [HC_W-1:0] a_al
);

  logic [HC_D-1:0] r_p1;
  logic [HC_D-1:0] r_vld;
  logic [HC_W-1:0] r_a [HC_D];
  logic            r_prev;
  logic            r_armed;
  logic            w_p1s;

  assign w_p1s = r_p1[HC_D-1];
  assign a_al  = r_a[HC_D-1];

  // Arming needs a genuinely sampled low, so a p1 already high at reset
  // release cannot masquerade as a rising edge against the cleared flops.
  assign cap = r_armed & w_p1s & ~r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1    <= '0;
      r_vld   <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      for (int i = 0; i < HC_D; i++) r_a[i] <= '0;
    end else begin
      r_p1[0]  <= p1;
      r_vld[0] <= 1'b1;
      r_a[0]   <= a;
      for (int i = 1; i < HC_D; i++) begin
        r_p1[i]  <= r_p1[i-1];
        r_vld[i] <= r_vld[i-1];
        r_a[i]   <= r_a[i-1];
      end
      r_prev  <= w_p1s;
      r_armed <= r_armed | (r_vld[HC_D-1] & ~w_p1s);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hc646n.sv
// ============================================================================
// hc646n : octal registered bus transceiver (A to B) with turnaround FSM.
// Macro  : HC646N_SYNC_EN deepens the p1/A input pipeline to 2 stages.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hc646n import hc_pkg::*; (
  input wire logic  clk,
  input wire logic  rst,
  hc646n_if.slave   bus
);

  logic [HC_W-1:0] r_reg;
  logic [HC_W-1:0] w_a_al;
  logic            w_cap;
  logic            w_en;
  hc_state_e       r_state;
  hc_state_e       w_next;

  hc_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .p1   (bus.p1),
    .a    (bus.a),
    .cap  (w_cap),
    .a_al (w_a_al)
  );

  assign w_en = ~bus.p21 & bus.p3;

  always_ff @(posedge clk) begin
    if (rst)        r_reg <= '0;
    else if (w_cap) r_reg <= w_a_al;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= HIZ;
    else     r_state <= w_next;
  end

  // TURN holds B released for one cycle before driving.
  always_comb begin
    w_next = r_state;
    case (r_state)
      HIZ:     if (w_en)  w_next = TURN;
      TURN:    w_next = w_en ? DRIVE : HIZ;
      DRIVE:   if (!w_en) w_next = HIZ;
      default: w_next = HIZ;
    endcase
  end

  always_comb begin
    bus.b_oe  = (r_state == DRIVE);
    bus.b_dat = bus.p2 ? r_reg : bus.a;
  end

endmodule

`default_nettype wire

// File: tb/tb_hc646n.sv
// ============================================================================
// tb_hc646n : vector table, directed corner sequences and random run for hc646n.
// Rev       : 1.0
// ============================================================================
`default_nettype none

module tb_hc646n;

`ifdef HC646N_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic clk;
  logic rst;
  hc646n_if bus ();

  hc646n u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: per-edge sample history since reset, register, and
  // the length of the current run of enabled edges.
  bit         hp1[$];
  logic [7:0] ha[$];
  logic [7:0] mreg;
  int         mrun;

  task automatic model_edge();
    int n, j;
    if (rst) begin
      hp1.delete();
      ha.delete();
      mreg = 8'h00;
      mrun = 0;
    end else begin
      hp1.push_back(bus.p1);
      ha.push_back(bus.a);
      n = hp1.size();
      j = n - D;
      // Sample j is a rising edge if an earlier post-reset sample was low.
      if (j >= 2 && hp1[j-1] && !hp1[j-2]) mreg = ha[j-1];
      if (!bus.p21 && bus.p3) mrun = (mrun < 2) ? mrun + 1 : 2;
      else                    mrun = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic step(input bit ip1, input bit ip2, input bit ip3, input bit ip21,
                      input logic [7:0] ia, input bit irst);
    rst     = irst;
    bus.p1  = ip1;
    bus.p2  = ip2;
    bus.p3  = ip3;
    bus.p21 = ip21;
    bus.a   = ia;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit         rst;
    bit         p2;
    bit         p3;
    bit         p21;
    logic [7:0] a;
    bit         exp_oe;
    logic [7:0] exp_b;
  } vec_t;

  vec_t tbl[12];

  initial begin
    rst = 1'b1; bus.p1 = 0; bus.p2 = 0; bus.p3 = 0; bus.p21 = 1; bus.a = 8'h00;
    mreg = 8'h00; mrun = 0;

    //          rst p2 p3 p21  a      oe b
    tbl[0]  = '{1, 0, 1, 0, 8'h5A, 0, 8'h00};
    tbl[1]  = '{0, 0, 1, 0, 8'h5A, 0, 8'h00};
    tbl[2]  = '{0, 0, 1, 0, 8'h5A, 1, 8'h5A};
    tbl[3]  = '{0, 0, 1, 0, 8'h3C, 1, 8'h3C};
    tbl[4]  = '{0, 0, 1, 1, 8'h3C, 0, 8'h00};
    tbl[5]  = '{0, 0, 1, 0, 8'h3C, 0, 8'h00};
    tbl[6]  = '{0, 0, 1, 0, 8'h11, 1, 8'h11};
    tbl[7]  = '{0, 0, 0, 0, 8'h11, 0, 8'h00};
    tbl[8]  = '{0, 0, 1, 0, 8'h11, 0, 8'h00};
    tbl[9]  = '{0, 1, 1, 0, 8'h77, 1, 8'h00};
    tbl[10] = '{0, 0, 1, 0, 8'h77, 1, 8'h77};
    tbl[11] = '{0, 1, 1, 0, 8'h77, 1, 8'h00};

    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].p2, tbl[i].p3, tbl[i].p21, tbl[i].a, tbl[i].rst);
      chk($sformatf("tbl%0d_oe", i), {7'd0, bus.b_oe}, {7'd0, tbl[i].exp_oe});
      if (tbl[i].exp_oe) chk($sformatf("tbl%0d_b", i), bus.b, tbl[i].exp_b);
    end

    // Live A reaches B combinationally without a clock edge.
    bus.p2 = 0; bus.a = 8'h96; #1;
    chk("comb_a", bus.b, 8'h96);

    // Capture latency with A changing right after the first p1 edge.
    step(0, 0, 1, 0, 8'h00, 1);
    repeat (3) step(0, 0, 1, 0, 8'h00, 0);
    step(0, 1, 1, 0, 8'hC3, 0);
    for (int k = 1; k <= D + 2; k++) begin
      step(1, 1, 1, 0, (k == 1) ? 8'hC3 : 8'h00, 0);
      chk($sformatf("cap_lat_e%0d", k), bus.b, (k >= D + 1) ? 8'hC3 : 8'h00);
    end

    // p1 held high with A changing every cycle: one capture only.
    repeat (2) step(0, 1, 1, 0, 8'h00, 0);
    for (int k = 1; k <= 10; k++) begin
      step(1, 1, 1, 0, 8'h10 + 8'(k), 0);
      if (k >= D + 1) chk($sformatf("hold_e%0d", k), bus.b, 8'h11);
    end
    repeat (3) step(0, 1, 1, 0, 8'hEE, 0);
    chk("hold_after", bus.b, 8'h11);

    // OE# toggling out of DRIVE and back through TURN.
    step(0, 1, 1, 1, 8'h00, 0);
    chk("oe_off", {7'd0, bus.b_oe}, 8'h00);
    step(0, 1, 1, 0, 8'h00, 0);
    chk("oe_turn", {7'd0, bus.b_oe}, 8'h00);
    step(0, 1, 1, 0, 8'h00, 0);
    chk("oe_back", {7'd0, bus.b_oe}, 8'h01);

    // DIR low: B stays released while captures still land.
    step(0, 1, 0, 0, 8'hA5, 0);
    step(1, 1, 0, 0, 8'hA5, 0);
    for (int k = 0; k < D + 3; k++) begin
      step(1, 1, 0, 0, 8'h00, 0);
      chk($sformatf("dir0_z%0d", k), {7'd0, bus.b_oe}, 8'h00);
    end
    step(1, 1, 1, 0, 8'h00, 0);
    step(1, 1, 1, 0, 8'h00, 0);
    chk("dir0_reg", bus.b, 8'hA5);

    // Reset one cycle after a p1 rise aborts the capture.
    step(0, 1, 1, 0, 8'hFF, 0);
    step(0, 1, 1, 0, 8'hFF, 0);
    step(1, 1, 1, 0, 8'hFF, 0);
    step(1, 1, 1, 0, 8'hFF, 1);
    chk("rst_oe", {7'd0, bus.b_oe}, 8'h00);
    for (int k = 0; k < D + 3; k++) step(1, 1, 1, 0, 8'hFF, 0);
    chk("rst_noncap", bus.b, 8'h00);
    step(0, 1, 1, 0, 8'hFF, 0);
    step(1, 1, 1, 0, 8'hFF, 0);
    for (int k = 0; k < D; k++) step(1, 1, 1, 0, 8'h00, 0);
    chk("rst_recap", bus.b, 8'hFF);

    // Randomised traffic against the model.
    begin
      bit cp1 = 0;
      step(0, 0, 1, 0, 8'h00, 1);
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) cp1 = ~cp1;
        step(cp1, 1'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
             8'($urandom), ($urandom_range(0, 99) < 2));
        chk($sformatf("rnd%0d_oe", i), {7'd0, bus.b_oe}, {7'd0, (mrun >= 2)});
        if (mrun >= 2) chk($sformatf("rnd%0d_b", i), bus.b, bus.p2 ? mreg : bus.a);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hc646n.md
HC646N -- requirements
Module: hc646n

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 p1  input  1  CPAB, register clock pin, asynchronous to clk.
REQ-004 p2  input  1  SAB: 0 = live A to B, 1 = stored register to B.
REQ-005 p3  input  1  DIR; B is driven only when p3=1 (A to B direction).
REQ-006 p21  input  1  OE#, active-low output enable.
REQ-007 p4..p11  input  8  port A bits A1..A8, p4 = A1.
REQ-008 p20..p13  output  8  port B bits B1..B8, p20 = B1, 3-state.
REQ-009 Parameter-free; data width is fixed at 8.

Function
REQ-010 Block SHALL sample p1 and A through an input pipeline of depth D, with D=2 when HC646N_SYNC_EN is defined and D=1 otherwise.
REQ-011 A rising edge on p1 SHALL be detected as synchronised p1 = 1 while its previous sampled value = 0, giving a one-cycle capture pulse.
REQ-012 On a capture pulse, the 8-bit register SHALL load A as sampled on the same clk edge that first saw p1 = 1 (A pipeline depth equals p1 pipeline depth).
REQ-013 Capture latency: the register SHALL be updated on rising clk edge D+1, counting the first edge with p1 = 1 as edge 1.
REQ-014 p1 held high SHALL produce exactly one capture; a p1 pulse narrower than one clk period MAY be missed and SHALL never produce two captures.
REQ-015 Enable condition en = (p21==0) && (p3==1), evaluated on raw pins each clk edge.
REQ-016 Output FSM with states HIZ, TURN, DRIVE:
  - HIZ -> TURN when en=1.
  - TURN -> DRIVE when en=1; TURN -> HIZ when en=0.
  - DRIVE -> HIZ when en=0.
REQ-017 B SHALL be 8'hZZ in HIZ and TURN, giving one clk cycle of bus turnaround.
REQ-018 In DRIVE, B SHALL be combinational: p2=0 gives live raw A, p2=1 gives register contents.
REQ-019 Disable SHALL be at most one cycle late: B goes to Z on the first clk edge where en=0.
REQ-020 Capture and p2=1 in the same cycle: B SHALL show the old register value that cycle and the new value from the next cycle.
REQ-021 Toggling p2 in DRIVE SHALL NOT leave DRIVE.

Reset
REQ-022 While rst=1 at a clk edge: register = 8'h00, all pipeline and edge flops = 0, FSM = HIZ, B = 8'hZZ.
REQ-023 Reset mid-operation SHALL abort any pending capture; no capture SHALL result from a p1 edge seen before reset.
REQ-024 If p1 is already high when rst falls, it SHALL NOT capture until p1 goes low and then high again.

Configuration
REQ-025 Macro HC646N_SYNC_EN:
  - Defined: 2-flop synchroniser on p1 and matching 2-deep A pipeline; capture latency 3 edges.
  - Undefined: single flop on p1 and A; capture latency 2 edges.
  - FSM behaviour is identical in both cases.

Structure
REQ-026 Shared package hc_pkg SHALL hold HC_W = 8 and the output-FSM state enum (HIZ, TURN, DRIVE).
REQ-027 Sub-module hc_edge_sync SHALL contain the p1 synchroniser, the A pipeline and the edge detector, and output the capture pulse and aligned A.
REQ-028 Top level SHALL hold the register, the FSM and the B tri-state mux.

Verification
REQ-029 Reset then p21=0, p3=1, p2=0, A=8'h5A: B is Z for edges 1..2, equals 8'h5A after edge 2, tracks A changes combinationally.
REQ-030 A=8'hC3, p1 rises, A changes to 8'h00 one cycle later, p2=1 in DRIVE: B=8'h00 (old register) until edge D+1, then 8'hC3.
REQ-031 p21 goes to 1 in DRIVE: B=Z after the next edge; p21 back to 0: Z for one more cycle (TURN), then driven.
REQ-032 p3=0 with p21=0: B stays Z indefinitely, and captures still update the register (checked by later enabling with p2=1).
REQ-033 p1 held high for 10 cycles with A changing every cycle: exactly one capture, at the first edge's value.
REQ-034 rst pulsed one cycle after p1 rises with A=8'hFF: register = 8'h00 and B = Z; no capture until a fresh p1 rising edge.
